// File: rtl/bsd_pkg.sv
// Shared types and helpers for the bit stream deserializer: FSM state encoding
// and a width-generic parity function.
package bsd_pkg;

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int MAX_WORD_W = 32;

  // Callers zero-extend narrower words; the extra zero bits leave parity unchanged.
  function automatic logic parity_of(input logic [MAX_WORD_W-1:0] w);
    return ^w;
  endfunction

endpackage

// File: rtl/bit_stream_deserializer_if.sv
// Word output bus of the deserializer: assembled word, its parity, and a
// valid/ready handshake.
interface bit_stream_deserializer_if #(
  parameter int WORD_W = 8
) ();

  logic [WORD_W-1:0] word_out;
  logic              word_parity;
  logic              word_valid;
  logic              word_ready;

  modport master (output word_out, output word_parity, output word_valid, input word_ready);
  modport slave  (input word_out, input word_parity, input word_valid, output word_ready);

endinterface

// File: rtl/bsd_out_buf.sv
// One-entry valid/ready output slice. A completed word that finds the slot full
// and not draining is dropped, and the sticky overflow flag is set.
module bsd_out_buf
  import bsd_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                load,
  input  logic [WORD_W-1:0]   load_word,
  input  logic                clear_flags,
  bit_stream_deserializer_if.master word_bus,
  output logic                overflow
);

  logic [WORD_W-1:0] word_reg;
  logic              parity_reg;
  logic              valid_reg;
  logic              overflow_reg;
  logic              can_load;
  logic              drop;

  // A pop in the same cycle frees the slot, so the new word loads with no bubble.
  assign can_load = !valid_reg || word_bus.word_ready;
  assign drop     = load && !can_load;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      word_reg     <= '0;
      parity_reg   <= 1'b0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (load && can_load) begin
        word_reg   <= load_word;
        parity_reg <= parity_of(MAX_WORD_W'(load_word));
        valid_reg  <= 1'b1;
      end else if (valid_reg && word_bus.word_ready) begin
        valid_reg <= 1'b0;
      end

      if (drop) begin
        overflow_reg <= 1'b1;
      end else if (clear_flags) begin
        overflow_reg <= 1'b0;
      end
    end
  end

  assign word_bus.word_out    = word_reg;
  assign word_bus.word_parity = parity_reg;
  assign word_bus.word_valid  = valid_reg;
  assign overflow             = overflow_reg;

endmodule

// File: rtl/bit_stream_deserializer.sv
// Packs a qualified serial bit stream LSB-first into WORD_W-bit words, with
// frame hunting, mid-word re-sync detection and a one-entry output buffer.
module bit_stream_deserializer
  import bsd_pkg::*;
#(
  parameter int WORD_W = 8
) (
  input  logic clock,
  input  logic reset_n,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic frame_start,
  input  logic clear_flags,
  output logic overflow,
  output logic frame_err,
  bit_stream_deserializer_if.master word_bus
);

  localparam int                CNT_W = $clog2(WORD_W);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [WORD_W-1:0] shift_reg, shift_next;
  logic              frame_err_reg;
  logic              frame_err_set;
  logic              complete;

  always_comb begin
    state_next    = state_reg;
    count_next    = count_reg;
    shift_next    = shift_reg;
    frame_err_set = 1'b0;
    complete      = 1'b0;
    if (bit_valid) begin
      case (state_reg)
        HUNT: begin
          if (frame_start) begin
            shift_next    = '0;
            shift_next[0] = bit_in;
            count_next    = ONE;
            state_next    = SHIFT;
          end
        end
        SHIFT: begin
          if (frame_start && (count_reg != '0)) begin
            frame_err_set = 1'b1;
            shift_next    = '0;
            shift_next[0] = bit_in;
            count_next    = ONE;
          end else begin
            shift_next[count_reg] = bit_in;
            // Explicit wrap: WORD_W need not be a power of two.
            if (count_reg == LAST) begin
              count_next = '0;
              complete   = 1'b1;
            end else begin
              count_next = count_reg + ONE;
            end
          end
        end
        default: state_next = HUNT;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg     <= HUNT;
      count_reg     <= '0;
      shift_reg     <= '0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      count_reg <= count_next;
      shift_reg <= shift_next;
      if (frame_err_set) begin
        frame_err_reg <= 1'b1;
      end else if (clear_flags) begin
        frame_err_reg <= 1'b0;
      end
    end
  end

  assign frame_err = frame_err_reg;

  // The buffer captures shift_next so the word is visible on the edge that samples its last bit.
  bsd_out_buf #(
    .WORD_W(WORD_W)
  ) u_out_buf (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (complete),
    .load_word  (shift_next),
    .clear_flags(clear_flags),
    .word_bus   (word_bus),
    .overflow   (overflow)
  );

endmodule

// File: tb/tb_bit_stream_deserializer.sv
// Directed and randomized bench for bit_stream_deserializer (WORD_W=8), checked
// against a queue-based reference model of the framing and buffer rules.
module tb_bit_stream_deserializer;

  logic clock = 1'b0;
  logic reset_n;
  logic bit_in;
  logic bit_valid;
  logic frame_start;
  logic clear_flags;
  logic overflow;
  logic frame_err;

  int total = 0;
  int bad   = 0;

  bit_stream_deserializer_if #(.WORD_W(8)) wb ();

  bit_stream_deserializer #(
    .WORD_W(8)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .frame_start(frame_start),
    .clear_flags(clear_flags),
    .overflow   (overflow),
    .frame_err  (frame_err),
    .word_bus   (wb)
  );

  always #5 clock = ~clock;

  // Reference model state
  int       pend[$];
  bit       locked = 0;
  bit [7:0] m_word = '0;
  bit       m_valid = 0;
  bit       m_par = 0;
  bit       m_ovf = 0;
  bit       m_ferr = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input bit b, input bit v, input bit fs, input bit rdy,
                            input bit clr, input bit rn);
    bit       done;
    bit       ovf_set;
    bit       ferr_set;
    bit [7:0] w;
    done     = 0;
    ovf_set  = 0;
    ferr_set = 0;
    w        = '0;
    if (!rn) begin
      pend.delete();
      locked  = 0;
      m_word  = '0;
      m_valid = 0;
      m_par   = 0;
      m_ovf   = 0;
      m_ferr  = 0;
      return;
    end
    if (v) begin
      if (!locked) begin
        if (fs) begin
          locked = 1;
          pend.delete();
          pend.push_back(int'(b));
        end
      end else if (fs && pend.size() != 0) begin
        ferr_set = 1;
        pend.delete();
        pend.push_back(int'(b));
      end else begin
        pend.push_back(int'(b));
        if (pend.size() == 8) begin
          foreach (pend[i]) w[i] = pend[i][0];
          done = 1;
          pend.delete();
        end
      end
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_word  = w;
        m_valid = 1;
        m_par   = ($countones(w) % 2) == 1;
      end else begin
        ovf_set = 1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 0;
    end
    m_ovf  = ovf_set  ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_ferr = ferr_set ? 1'b1 : (clr ? 1'b0 : m_ferr);
  endtask

  task automatic cyc(input bit b, input bit v, input bit fs, input bit rdy, input bit clr);
    @(negedge clock);
    bit_in        = b;
    bit_valid     = v;
    frame_start   = fs;
    wb.word_ready = rdy;
    clear_flags   = clr;
    @(posedge clock);
    model_step(b, v, fs, rdy, clr, reset_n);
    #1;
    chk("word_valid", 32'(wb.word_valid), 32'(m_valid));
    chk("word_out", 32'(wb.word_out), 32'(m_word));
    chk("word_parity", 32'(wb.word_parity), 32'(m_par));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("frame_err", 32'(frame_err), 32'(m_ferr));
  endtask

  task automatic send(input logic [7:0] w, input bit framed, input bit rdy, input bit rdy_last);
    for (int i = 0; i < 8; i++) begin
      cyc(w[i], 1'b1, framed && (i == 0), (i == 7) ? rdy_last : rdy, 1'b0);
    end
  endtask

  task automatic chk_word(input string tag, input logic [7:0] w, input bit par);
    chk({tag, "_valid"}, 32'(wb.word_valid), 32'd1);
    chk({tag, "_word"}, 32'(wb.word_out), 32'(w));
    chk({tag, "_parity"}, 32'(wb.word_parity), 32'(par));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_word"}, 32'(wb.word_out), 32'd0);
    chk({tag, "_parity"}, 32'(wb.word_parity), 32'd0);
    chk({tag, "_valid"}, 32'(wb.word_valid), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_ferr"}, 32'(frame_err), 32'd0);
  endtask

  initial begin
    bit_in        = 1'b0;
    bit_valid     = 1'b0;
    frame_start   = 1'b0;
    clear_flags   = 1'b0;
    wb.word_ready = 1'b0;
    reset_n       = 1'b0;

    // Reset state
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk_all_zero("reset");
    reset_n = 1'b1;

    // 1: framed 0xA5 at full rate, consumer always ready
    send(8'hA5, 1'b1, 1'b1, 1'b1);
    chk_word("t1", 8'hA5, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t1_one_cycle", 32'(wb.word_valid), 32'd0);
    $display("txn t1 word=%02h", 8'hA5);

    // 2: unframed bits ignored while hunting
    reset_n = 1'b0;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    reset_n = 1'b1;
    send(8'hFF, 1'b0, 1'b1, 1'b1);
    chk("t2_hunt_quiet", 32'(wb.word_valid), 32'd0);
    send(8'h3C, 1'b1, 1'b1, 1'b1);
    chk_word("t2", 8'h3C, 1'b0);
    $display("txn t2 word=%02h", 8'h3C);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 3: back-to-back with consumer stalled -> drop and overflow
    send(8'h01, 1'b1, 1'b0, 1'b0);
    send(8'h80, 1'b0, 1'b0, 1'b0);
    chk_word("t3_held", 8'h01, 1'b1);
    chk("t3_ovf", 32'(overflow), 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t3_ovf_clr", 32'(overflow), 32'd0);
    chk_word("t3_after_clr", 8'h01, 1'b1);
    $display("txn t3 held=%02h", 8'h01);

    // 4: pop coincides with completion -> replace without overflow
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    send(8'h01, 1'b1, 1'b0, 1'b0);
    send(8'h80, 1'b0, 1'b0, 1'b1);
    chk_word("t4", 8'h80, 1'b1);
    chk("t4_ovf", 32'(overflow), 32'd0);
    $display("txn t4 word=%02h", 8'h80);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // 5: partial word then re-sync, with idle gaps inside the new word
    for (int i = 0; i < 5; i++) cyc(1'b1, 1'b1, i == 0, 1'b1, 1'b0);
    begin
      logic [7:0] w5;
      w5 = 8'h5A;
      for (int i = 0; i < 8; i++) begin
        cyc(w5[i], 1'b1, i == 0, 1'b1, 1'b0);
        if (i == 0) chk("t5_ferr", 32'(frame_err), 32'd1);
        if (i == 2 || i == 5) cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      end
    end
    chk_word("t5", 8'h5A, 1'b0);
    $display("txn t5 word=%02h", 8'h5A);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    chk("t5_ferr_clr", 32'(frame_err), 32'd0);

    // 6: reset mid-word discards partial bits
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
    reset_n = 1'b0;
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk_all_zero("t6_reset");
    reset_n = 1'b1;
    send(8'hC3, 1'b1, 1'b1, 1'b1);
    chk_word("t6", 8'hC3, 1'b0);
    $display("txn t6 word=%02h", 8'hC3);

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      reset_n = ($urandom_range(0, 79) != 0);
      cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 15) == 0);
    end
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
